// File: rtl/sign_pkg.sv
// Shared definitions for the multi-channel sign/change detector: mode encodings
// and the round-robin search used by the event slot.
package sign_pkg;

    localparam logic [1:0] MODE_ANY = 2'b00;
    localparam logic [1:0] MODE_INC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    localparam int unsigned MAX_CH   = 32;
    localparam int unsigned MAX_CH_W = 5;

    // First set bit of req at or after ptr+1 (mod n); returns ptr when req is empty.
    function automatic int unsigned rr_next(input logic [MAX_CH-1:0] req,
                                            input int unsigned       ptr,
                                            input int unsigned       n);
        int unsigned idx;
        logic        found;
        rr_next = ptr;
        found   = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (k <= n) && req[idx[MAX_CH_W-1:0]]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/sign_chan.sv
// One monitored channel: debounce against a candidate value, then qualify the
// accepted change by mode and raise a one-cycle flag.
module sign_chan
    import sign_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int STABLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] reg_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] val_o,
    output logic             flag_o,
    output logic             accept_o
);

    localparam int CNT_W = (STABLE > 0) ? $clog2(STABLE + 1) : 1;
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);

    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] val_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             flag_q;
    logic             change_d;
    logic             qual_d;
    logic             accept_d;

    always_comb begin
        cnt_d = '0;
        if (reg_i == cand_q) begin
            cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + 1'b1;
        end
        change_d = (cnt_d == STABLE_C) && (reg_i != val_q);
        qual_d   = 1'b0;
        case (mode_i)
            MODE_ANY: qual_d = 1'b1;
            MODE_INC: qual_d = (reg_i > val_q);
            MODE_DEC: qual_d = (reg_i < val_q);
            default:  qual_d = 1'b0;
        endcase
        accept_d = change_d && qual_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
            val_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cand_q <= reg_i;
            cnt_q  <= cnt_d;
            flag_q <= accept_d;
            if (change_d) begin
                val_q <= reg_i;
            end
        end
    end

    // Unregistered so the top can set pending on the acceptance edge itself.
    assign accept_o = accept_d;
    assign flag_o   = flag_q;
    assign val_o    = val_q;

endmodule

// File: rtl/multi_sign_det.sv
// Multi-channel debounced change detector with per-channel pending/overflow
// bits drained through a round-robin valid/ready event slot.
module multi_sign_det
    import sign_pkg::*;
#(
    parameter int CH     = 4,
    parameter int WIDTH  = 3,
    parameter int STABLE = 2,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*WIDTH-1:0] reg_in,
    input  logic [2*CH-1:0]     mode,
    output logic [CH-1:0]       flag_pulse,
    output logic [CH*WIDTH-1:0] val_out,
    output logic                evt_valid,
    output logic [CH_W-1:0]     evt_ch,
    output logic [WIDTH-1:0]    evt_val,
    input  logic                evt_ready,
    output logic [CH-1:0]       ovf,
    input  logic [CH-1:0]       ovf_clr
);

    logic [CH-1:0]    accept;
    logic [WIDTH-1:0] val_arr [CH];
    logic [CH-1:0]    pend_q, pend_d;
    logic [CH-1:0]    ovf_q, ovf_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CH_W-1:0]  grant;
    logic             load;
    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic [WIDTH-1:0] evt_val_q, evt_val_d;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            sign_chan #(
                .WIDTH  (WIDTH),
                .STABLE (STABLE)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .reg_i    (reg_in[gi*WIDTH +: WIDTH]),
                .mode_i   (mode[2*gi +: 2]),
                .val_o    (val_out[gi*WIDTH +: WIDTH]),
                .flag_o   (flag_pulse[gi]),
                .accept_o (accept[gi])
            );
            assign val_arr[gi] = val_out[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        pend_d      = pend_q;
        ovf_d       = ovf_q & ~ovf_clr;
        ptr_d       = ptr_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_val_d   = evt_val_q;
        grant       = CH_W'(rr_next(MAX_CH'(pend_q), 32'(ptr_q), 32'(CH)));
        load        = (|pend_q) && (!evt_valid_q || evt_ready);

        if (load) begin
            pend_d[grant] = 1'b0;
            ptr_d         = grant;
            evt_valid_d   = 1'b1;
            evt_ch_d      = grant;
            evt_val_d     = val_arr[grant];
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end

        // A re-arm on the same edge the slot takes this channel is not an overflow.
        for (int i = 0; i < CH; i++) begin
            if (accept[i]) begin
                if (pend_q[i] && !(load && (grant == CH_W'(i)))) begin
                    ovf_d[i] = 1'b1;
                end
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= '0;
            ovf_q       <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_val_q   <= '0;
        end else begin
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_val_q   <= evt_val_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_val   = evt_val_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multi_sign_det.sv
// Bench for multi_sign_det: two instances (STABLE=2 and STABLE=0) share stimulus
// and are compared each cycle with a sample-history model, plus directed vectors.
module tb_multi_sign_det;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] reg_in;
    logic [7:0]  mode;
    logic        evt_ready;
    logic [3:0]  ovf_clr;

    logic [3:0]  flag_a, flag_b, ovf_a, ovf_b;
    logic [11:0] val_a, val_b;
    logic        valid_a, valid_b;
    logic [1:0]  ch_a, ch_b;
    logic [2:0]  ev_a, ev_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_sign_det #(.CH(4), .WIDTH(3), .STABLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .reg_in(reg_in), .mode(mode),
        .flag_pulse(flag_a), .val_out(val_a), .evt_valid(valid_a), .evt_ch(ch_a),
        .evt_val(ev_a), .evt_ready(evt_ready), .ovf(ovf_a), .ovf_clr(ovf_clr)
    );

    multi_sign_det #(.CH(4), .WIDTH(3), .STABLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .reg_in(reg_in), .mode(mode),
        .flag_pulse(flag_b), .val_out(val_b), .evt_valid(valid_b), .evt_ch(ch_b),
        .evt_val(ev_b), .evt_ready(evt_ready), .ovf(ovf_b), .ovf_clr(ovf_clr)
    );

    // Reference model state, index 0 = STABLE 2 instance, 1 = STABLE 0 instance.
    int m_hist  [2][4][3];
    int m_val   [2][4];
    bit m_flag  [2][4];
    bit m_pend  [2][4];
    bit m_ovf   [2][4];
    int m_ptr   [2];
    bit m_valid [2];
    int m_ch    [2];
    int m_ev    [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int m);
        bit old_pend [4];
        int loaded, s, md, stab, j;
        bit chg, qual, st;
        stab = (m == 0) ? 2 : 0;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_val[m][i] = 0; m_flag[m][i] = 0; m_pend[m][i] = 0; m_ovf[m][i] = 0;
                for (int d = 0; d < 3; d++) m_hist[m][i][d] = -1;
            end
            m_ptr[m] = 0; m_valid[m] = 0; m_ch[m] = 0; m_ev[m] = 0;
            return;
        end
        for (int i = 0; i < 4; i++) old_pend[i] = m_pend[m][i];
        loaded = -1;
        if (!m_valid[m] || evt_ready) begin
            for (int k = 1; k <= 4; k++) begin
                j = (m_ptr[m] + k) % 4;
                if (loaded < 0 && old_pend[j]) loaded = j;
            end
            if (loaded >= 0) begin
                m_ch[m] = loaded; m_ev[m] = m_val[m][loaded];
                m_pend[m][loaded] = 0; m_ptr[m] = loaded; m_valid[m] = 1;
            end else begin
                m_valid[m] = 0;
            end
        end
        for (int i = 0; i < 4; i++) if (ovf_clr[i]) m_ovf[m][i] = 0;
        for (int i = 0; i < 4; i++) begin
            s  = int'(reg_in[i*3 +: 3]);
            md = int'(mode[2*i +: 2]);
            m_hist[m][i][2] = m_hist[m][i][1];
            m_hist[m][i][1] = m_hist[m][i][0];
            m_hist[m][i][0] = s;
            st = 1;
            for (int d = 0; d <= stab; d++) if (m_hist[m][i][d] != s) st = 0;
            chg  = st && (s != m_val[m][i]);
            qual = (md == 0) || (md == 1 && s > m_val[m][i]) || (md == 2 && s < m_val[m][i]);
            m_flag[m][i] = chg && qual;
            if (chg && qual) begin
                if (old_pend[i] && loaded != i) m_ovf[m][i] = 1;
                m_pend[m][i] = 1;
            end
            if (chg) m_val[m][i] = s;
        end
    endtask

    task automatic check_model();
        logic [3:0]  ef, eo;
        logic [11:0] evl;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                ef[i] = m_flag[m][i];
                eo[i] = m_ovf[m][i];
                evl[i*3 +: 3] = 3'(m_val[m][i]);
            end
            if (m == 0) begin
                chk("a_flag", flag_a, ef);   chk("a_val", val_a, evl);
                chk("a_valid", valid_a, m_valid[0]);
                chk("a_ch", ch_a, m_ch[0]);  chk("a_evval", ev_a, m_ev[0]);
                chk("a_ovf", ovf_a, eo);
            end else begin
                chk("b_flag", flag_b, ef);   chk("b_val", val_b, evl);
                chk("b_valid", valid_b, m_valid[1]);
                chk("b_ch", ch_b, m_ch[1]);  chk("b_evval", ev_b, m_ev[1]);
                chk("b_ovf", ovf_b, eo);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ch(input int c, input int v);
        reg_in[c*3 +: 3] = 3'(v);
    endtask

    typedef struct {
        logic        rst_n;
        logic [11:0] rin;
        logic [7:0]  md;
        logic [3:0]  fa;
        logic [11:0] va;
        logic        v;
        logic [1:0]  ch;
        logic [2:0]  ev;
        logic [3:0]  fb;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [11:0] rin, input logic [7:0] md,
                                input logic [3:0] fa, input logic [11:0] va, input logic v,
                                input int ch, input int ev, input logic [3:0] fb);
        vec_t t;
        t.rst_n = r; t.rin = rin; t.md = md; t.fa = fa; t.va = va; t.v = v;
        t.ch = 2'(ch); t.ev = 3'(ev); t.fb = fb;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; reg_in = '0; mode = '0; evt_ready = 1'b1; ovf_clr = '0;

        // Channel values are octal digits ch3,ch2,ch1,ch0; evt_ready held high.
        tbl.push_back(mk(0, 12'o0000, 8'h00, 4'b0000, 12'o0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 12'o0005, 8'h00, 4'b0000, 12'o0000, 0, 0, 0, 4'b0001));
        tbl.push_back(mk(1, 12'o0005, 8'h00, 4'b0000, 12'o0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 12'o0005, 8'h00, 4'b0001, 12'o0005, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 12'o0005, 8'h00, 4'b0000, 12'o0005, 1, 0, 5, 4'b0000));
        tbl.push_back(mk(1, 12'o0005, 8'h00, 4'b0000, 12'o0005, 0, 0, 5, 4'b0000));
        tbl.push_back(mk(1, 12'o0035, 8'h00, 4'b0000, 12'o0005, 0, 0, 5, 4'b0010));
        tbl.push_back(mk(1, 12'o0035, 8'h00, 4'b0000, 12'o0005, 0, 0, 5, 4'b0000));
        tbl.push_back(mk(1, 12'o0005, 8'h00, 4'b0000, 12'o0005, 0, 0, 5, 4'b0010));
        tbl.push_back(mk(1, 12'o0005, 8'h00, 4'b0000, 12'o0005, 0, 0, 5, 4'b0000));
        tbl.push_back(mk(1, 12'o0405, 8'h00, 4'b0000, 12'o0005, 0, 0, 5, 4'b0100));
        tbl.push_back(mk(1, 12'o0405, 8'h00, 4'b0000, 12'o0005, 0, 0, 5, 4'b0000));
        tbl.push_back(mk(1, 12'o0405, 8'h00, 4'b0100, 12'o0405, 0, 0, 5, 4'b0000));
        tbl.push_back(mk(1, 12'o0405, 8'h10, 4'b0000, 12'o0405, 1, 2, 4, 4'b0000));
        tbl.push_back(mk(1, 12'o0605, 8'h10, 4'b0000, 12'o0405, 0, 2, 4, 4'b0100));
        tbl.push_back(mk(1, 12'o0605, 8'h10, 4'b0000, 12'o0405, 0, 2, 4, 4'b0000));
        tbl.push_back(mk(1, 12'o0605, 8'h10, 4'b0100, 12'o0605, 0, 2, 4, 4'b0000));
        tbl.push_back(mk(1, 12'o0605, 8'h10, 4'b0000, 12'o0605, 1, 2, 6, 4'b0000));
        tbl.push_back(mk(1, 12'o0205, 8'h10, 4'b0000, 12'o0605, 0, 2, 6, 4'b0000));
        tbl.push_back(mk(1, 12'o0205, 8'h10, 4'b0000, 12'o0605, 0, 2, 6, 4'b0000));
        tbl.push_back(mk(1, 12'o0205, 8'h10, 4'b0000, 12'o0205, 0, 2, 6, 4'b0000));
        tbl.push_back(mk(1, 12'o0205, 8'h20, 4'b0000, 12'o0205, 0, 2, 6, 4'b0000));
        tbl.push_back(mk(1, 12'o0105, 8'h20, 4'b0000, 12'o0205, 0, 2, 6, 4'b0100));
        tbl.push_back(mk(1, 12'o0105, 8'h20, 4'b0000, 12'o0205, 0, 2, 6, 4'b0000));
        tbl.push_back(mk(1, 12'o0105, 8'h20, 4'b0100, 12'o0105, 0, 2, 6, 4'b0000));
        tbl.push_back(mk(1, 12'o0705, 8'h30, 4'b0000, 12'o0105, 1, 2, 1, 4'b0000));
        tbl.push_back(mk(1, 12'o0705, 8'h30, 4'b0000, 12'o0105, 0, 2, 1, 4'b0000));
        tbl.push_back(mk(1, 12'o0705, 8'h30, 4'b0000, 12'o0705, 0, 2, 1, 4'b0000));

        foreach (tbl[n]) begin
            rst_n = tbl[n].rst_n; reg_in = tbl[n].rin; mode = tbl[n].md;
            step();
            chk($sformatf("tbl%0d_flag_a", n), flag_a, tbl[n].fa);
            chk($sformatf("tbl%0d_val_a", n), val_a, tbl[n].va);
            chk($sformatf("tbl%0d_valid_a", n), valid_a, tbl[n].v);
            chk($sformatf("tbl%0d_ch_a", n), ch_a, tbl[n].ch);
            chk($sformatf("tbl%0d_evval_a", n), ev_a, tbl[n].ev);
            chk($sformatf("tbl%0d_flag_b", n), flag_b, tbl[n].fb);
        end

        // Simultaneous changes on ch0/1/3 while stalled; last grant was ch2, so order is 3,0,1.
        mode = '0; evt_ready = 1'b0; reg_in = 12'o4721;
        steps(3);
        chk("sim_flag", flag_a, 4'b1011);
        step();
        chk("sim_first_valid", valid_a, 1); chk("sim_first_ch", ch_a, 3); chk("sim_first_val", ev_a, 4);
        steps(2);
        chk("stall_valid", valid_a, 1); chk("stall_ch", ch_a, 3); chk("stall_val", ev_a, 4);
        evt_ready = 1'b1;
        step(); chk("drain1_ch", ch_a, 0); chk("drain1_val", ev_a, 1);
        step(); chk("drain2_ch", ch_a, 1); chk("drain2_val", ev_a, 2);
        step(); chk("drain_done", valid_a, 0);

        // Overflow on ch1 and merged pending event carrying the latest value.
        evt_ready = 1'b0;
        set_ch(1, 5); steps(3); chk("ovf_seq_flag", flag_a, 4'b0010);
        step(); chk("ovf_slot_ch", ch_a, 1); chk("ovf_slot_val", ev_a, 5);
        set_ch(1, 6); steps(3);
        set_ch(1, 3); steps(3); chk("ovf_set", ovf_a, 4'b0010);
        evt_ready = 1'b1;
        step(); chk("merged_valid", valid_a, 1); chk("merged_ch", ch_a, 1); chk("merged_val", ev_a, 3);
        step(); chk("merged_single", valid_a, 0);
        ovf_clr = 4'b0010; step(); ovf_clr = '0; chk("ovf_clr", ovf_a, 4'b0000);

        // Clear coinciding with a new overflow: the set wins.
        evt_ready = 1'b0;
        set_ch(1, 1); steps(4);
        set_ch(1, 2); steps(3);
        set_ch(1, 4); steps(2);
        ovf_clr = 4'b0010; step(); ovf_clr = '0;
        chk("ovf_set_wins", ovf_a, 4'b0010);

        // Reset while the slot is stalled and ch3 is mid-debounce.
        set_ch(3, 6); step();
        rst_n = 1'b0; step();
        chk("rst_flag", flag_a, 0); chk("rst_val", val_a, 0); chk("rst_valid", valid_a, 0);
        chk("rst_ch", ch_a, 0); chk("rst_evval", ev_a, 0); chk("rst_ovf", ovf_a, 0);
        rst_n = 1'b1; evt_ready = 1'b1;
        steps(3);
        chk("redetect_flag", flag_a, 4'b1111);
        chk("redetect_val", val_a, 12'o6741);

        // Randomised traffic checked against the model on both instances.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(3) == 0) set_ch(c, int'($urandom_range(7)));
            end
            if ($urandom_range(15) == 0) mode = 8'($urandom);
            evt_ready = ($urandom_range(3) != 0);
            ovf_clr   = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
            rst_n     = ($urandom_range(299) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
